// File: rtl/multi_user_pin_checker.sv
// -----------------------------------------------------------------------------
// multi_user_pin_checker
//   Multi-user PIN checker sitting between keypad/button debouncers and the
//   door/LED indicators. A session picks a user slot, shifts in NUM_DIGITS
//   digits, reads that user's stored PIN from an external synchronous ROM and
//   reports grant or deny. Consecutive failures are counted per user; reaching
//   MAX_TRIES locks the block for LOCKOUT_CYCLES clocks. A session that sees no
//   digit for TIMEOUT_CYCLES clocks is aborted with a deny.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   start          in   1-cycle pulse, begins a session for user_sel
//   user_sel       in   user slot, sampled only with start
//   digit_vld      in   1-cycle strobe qualifying user_inp
//   user_inp       in   one entered digit
//   rom_addr       out  registered ROM address (latched user)
//   rom_data       in   stored PIN, valid one clock after rom_addr changes
//   access_granted out  level, held until the next accepted start
//   access_denied  out  level, held until the next accepted start
//   locked         out  high for the whole lockout period
//   busy           out  high while collecting, fetching or comparing
// -----------------------------------------------------------------------------
module multi_user_pin_checker #(
  parameter  int DIGIT_W        = 4,
  parameter  int NUM_DIGITS     = 4,
  parameter  int NUM_USERS      = 8,
  parameter  int MAX_TRIES      = 3,
  parameter  int LOCKOUT_CYCLES = 16,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int PW             = DIGIT_W * NUM_DIGITS,
  localparam int UW             = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [UW-1:0]      user_sel,
  input  logic               digit_vld,
  input  logic [DIGIT_W-1:0] user_inp,
  output logic [UW-1:0]      rom_addr,
  input  logic [PW-1:0]      rom_data,
  output logic               access_granted,
  output logic               access_denied,
  output logic               locked,
  output logic               busy
);

  localparam int DW  = $clog2(NUM_DIGITS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW  = $clog2(MAX_TRIES + 1);
  localparam int UW1 = UW + 1;

  localparam logic [DW-1:0]  DIG_LAST  = DW'(NUM_DIGITS);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0]  FAIL_MAX  = FW'(MAX_TRIES);
  localparam logic [UW1-1:0] USER_LIM  = UW1'(NUM_USERS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_FETCH   = 3'd2,
    S_COMPARE = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          state_q,    state_d;
  logic [UW-1:0]   rom_addr_q, rom_addr_d;
  logic [PW-1:0]   shift_q,    shift_d;
  logic [DW-1:0]   dcnt_q,     dcnt_d;
  logic [TW-1:0]   timer_q,    timer_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            granted_q,  granted_d;
  logic            denied_q,   denied_d;
  logic            locked_q,   locked_d;
  logic            busy_q,     busy_d;
  logic [FW-1:0]   fail_cnt_q [NUM_USERS];
  logic [FW-1:0]   fail_cnt_d [NUM_USERS];

  logic            user_ok;
  logic [FW-1:0]   cur_fail;
  logic [FW-1:0]   fail_next;

  assign user_ok        = ({1'b0, user_sel} < USER_LIM);
  assign rom_addr       = rom_addr_q;
  assign access_granted = granted_q;
  assign access_denied  = denied_q;
  assign locked         = locked_q;
  assign busy           = busy_q;

  // Next-state, datapath and registered-output decode for the session FSM.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    shift_d    = shift_q;
    dcnt_d     = dcnt_q;
    timer_d    = timer_q;
    lock_cnt_d = lock_cnt_q;
    granted_d  = granted_q;
    denied_d   = denied_q;
    fail_cnt_d = fail_cnt_q;

    cur_fail = fail_cnt_q[rom_addr_q];
    if (cur_fail >= FAIL_MAX) begin
      fail_next = FAIL_MAX;
    end else begin
      fail_next = cur_fail + FW'(1);
    end

    // A start is honoured only between lookups; mid-collect it discards the
    // partial entry and begins afresh.
    if (start && ((state_q == S_IDLE) || (state_q == S_COLLECT))) begin
      granted_d = 1'b0;
      if (user_ok) begin
        denied_d   = 1'b0;
        rom_addr_d = user_sel;
        shift_d    = '0;
        dcnt_d     = '0;
        timer_d    = '0;
        state_d    = S_COLLECT;
      end else begin
        denied_d = 1'b1;
        state_d  = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_COLLECT: begin
          // The cycle after the last digit lands is spent here, which puts
          // the result three edges after the capturing edge.
          if (dcnt_q == DIG_LAST) begin
            state_d = S_FETCH;
          end else if (digit_vld) begin
            shift_d = {shift_q[PW-DIGIT_W-1:0], user_inp};
            dcnt_d  = dcnt_q + DW'(1);
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            granted_d = 1'b0;
            denied_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_FETCH: begin
          state_d = S_COMPARE;
        end
        S_COMPARE: begin
          if (rom_data == shift_q) begin
            granted_d              = 1'b1;
            denied_d               = 1'b0;
            fail_cnt_d[rom_addr_q] = '0;
            state_d                = S_IDLE;
          end else begin
            granted_d              = 1'b0;
            denied_d               = 1'b1;
            fail_cnt_d[rom_addr_q] = fail_next;
            if (fail_next == FAIL_MAX) begin
              lock_cnt_d = '0;
              state_d    = S_LOCKOUT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt_q == LOCK_LAST) begin
            fail_cnt_d[rom_addr_q] = '0;
            state_d                = S_IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d   = (state_d == S_COLLECT) || (state_d == S_FETCH) || (state_d == S_COMPARE);
    locked_d = (state_d == S_LOCKOUT);
  end

  // State, datapath and output registers; reset returns to an idle, unlocked block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      shift_q    <= '0;
      dcnt_q     <= '0;
      timer_q    <= '0;
      lock_cnt_q <= '0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      fail_cnt_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      shift_q    <= shift_d;
      dcnt_q     <= dcnt_d;
      timer_q    <= timer_d;
      lock_cnt_q <= lock_cnt_d;
      granted_q  <= granted_d;
      denied_q   <= denied_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

endmodule
